// File: rtl/sa_cache_tag_array_pkg.sv
// cache_tag_pkg: op/state encodings and per-way entry type for sa_cache_tag_array.
// CACHE_TAG_PARITY_EN adds an even-parity bit over {valid, tag} to each entry.
package cache_tag_pkg;

   // Entries carry the widest supported tag; narrower arrays keep upper bits at zero.
   localparam int unsigned TAG_W_MAX = 32;

   typedef enum logic [1:0] {
      OP_LOOKUP = 2'd0,
      OP_FILL   = 2'd1,
      OP_INVAL  = 2'd2,
      OP_NOP    = 2'd3
   } tag_op_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } tag_state_e;

   typedef struct packed {
      logic                 valid;
      logic                 dirty;
      logic [TAG_W_MAX-1:0] tag;
`ifdef CACHE_TAG_PARITY_EN
      logic                 parity;
`endif
   } tag_entry_t;

   function automatic logic entry_parity(input logic valid, input logic [TAG_W_MAX-1:0] tag);
      return ^{valid, tag};
   endfunction

endpackage

// File: rtl/sa_cache_tag_array_plru_tree.sv
// plru_tree: tree pseudo-LRU update and victim select for one set.
// Heap-ordered bits; a set bit steers the victim walk to the upper half of its subtree.
module plru_tree #(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-2:0]  i_bits,
   input  logic [WAY_W-1:0] i_way,
   output logic [WAYS-2:0]  o_bits,
   output logic [WAY_W-1:0] o_victim
);

   always_comb begin
      o_bits   = i_bits;
      o_victim = '0;
      for (int l = 0; l < WAY_W; l++) begin
         o_bits[(1 << l) - 1 + int'(i_way >> (WAY_W - l))] = ~i_way[WAY_W-1-l];
         o_victim[WAY_W-1-l] = i_bits[(1 << l) - 1 + int'(o_victim >> (WAY_W - l))];
      end
   end

endmodule

// File: rtl/sa_cache_tag_array.sv
// sa_cache_tag_array: set-associative tag/valid/dirty array with tree-PLRU and clear sequencer.
// Define CACHE_TAG_PARITY_EN to store and check an even-parity bit per way.
module sa_cache_tag_array
   import cache_tag_pkg::*;
#(
   parameter int unsigned WAYS  = 4,
   parameter int unsigned SETS  = 1024,
   parameter int unsigned TAG_W = 18,
   parameter int unsigned IDX_W = $clog2(SETS),
   parameter int unsigned WAY_W = $clog2(WAYS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [IDX_W-1:0] req_index,
   input  logic [TAG_W-1:0] req_tag,
   input  logic [WAY_W-1:0] req_way,
   input  logic             req_write,
   input  logic             flush_start,
   output logic             flush_busy,
   output logic             resp_valid,
   output logic             resp_hit,
   output logic [WAY_W-1:0] resp_way,
   output logic             resp_dirty,
   output logic [TAG_W-1:0] resp_victim_tag,
   output logic             resp_victim_valid,
   output logic             parity_err
);

   tag_state_e       r_state;
   logic [IDX_W-1:0] r_clr_idx;
   tag_entry_t       r_mem  [SETS][WAYS];
   logic [WAYS-2:0]  r_plru [SETS];
   logic             r_resp_valid, r_resp_hit, r_resp_dirty, r_resp_victim_valid;
   logic [WAY_W-1:0] r_resp_way;
   logic [TAG_W-1:0] r_resp_victim_tag;

   tag_op_e          w_op;
   logic             w_accept, w_hit, w_any_inv;
   logic [WAYS-1:0]  w_match;
   logic [WAY_W-1:0] w_hit_way, w_inv_way, w_plru_victim, w_victim, w_resp_way, w_acc_way;
   logic [WAYS-2:0]  w_plru_next;
   tag_entry_t       w_fill_entry;

   assign w_op      = tag_op_e'(req_op);
   assign req_ready = (r_state == ST_IDLE);
   assign flush_busy = (r_state == ST_CLEAR);
   assign w_accept  = req_valid && req_ready;

`ifdef CACHE_TAG_PARITY_EN
   logic [WAYS-1:0] w_perr;
   logic            r_parity_err;
   assign parity_err = r_parity_err;
`else
   assign parity_err = 1'b0;
`endif

   // Descending scan so the lowest matching / invalid way wins.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      w_any_inv = 1'b0;
      w_inv_way = '0;
      w_match   = '0;
`ifdef CACHE_TAG_PARITY_EN
      w_perr    = '0;
`endif
      for (int w = WAYS - 1; w >= 0; w--) begin
`ifdef CACHE_TAG_PARITY_EN
         w_perr[w]  = r_mem[req_index][w].parity != entry_parity(r_mem[req_index][w].valid, r_mem[req_index][w].tag);
         w_match[w] = r_mem[req_index][w].valid && (r_mem[req_index][w].tag == TAG_W_MAX'(req_tag)) && !w_perr[w];
`else
         w_match[w] = r_mem[req_index][w].valid && (r_mem[req_index][w].tag == TAG_W_MAX'(req_tag));
`endif
         if (w_match[w]) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
         if (!r_mem[req_index][w].valid) begin
            w_any_inv = 1'b1;
            w_inv_way = WAY_W'(w);
         end
      end
   end

   assign w_victim   = w_any_inv ? w_inv_way : w_plru_victim;
   assign w_resp_way = w_hit ? w_hit_way : w_victim;
   assign w_acc_way  = (w_op == OP_FILL) ? req_way : w_hit_way;

   always_comb begin
      w_fill_entry       = '0;
      w_fill_entry.valid = 1'b1;
      w_fill_entry.dirty = req_write;
      w_fill_entry.tag   = TAG_W_MAX'(req_tag);
`ifdef CACHE_TAG_PARITY_EN
      w_fill_entry.parity = entry_parity(1'b1, TAG_W_MAX'(req_tag));
`endif
   end

   plru_tree #(.WAYS(WAYS), .WAY_W(WAY_W)) u_plru (
      .i_bits   (r_plru[req_index]),
      .i_way    (w_acc_way),
      .o_bits   (w_plru_next),
      .o_victim (w_plru_victim)
   );

   // Storage has no reset; the clear sequencer owns initialisation.
   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) begin
         for (int w = 0; w < WAYS; w++) r_mem[r_clr_idx][w] <= '0;
         r_plru[r_clr_idx] <= '0;
      end else if (w_accept) begin
         if (w_op == OP_FILL) begin
            r_mem[req_index][req_way] <= w_fill_entry;
            r_plru[req_index]         <= w_plru_next;
         end
         if (w_op == OP_INVAL) begin
            r_mem[req_index][req_way].valid <= 1'b0;
            r_mem[req_index][req_way].dirty <= 1'b0;
`ifdef CACHE_TAG_PARITY_EN
            r_mem[req_index][req_way].parity <= entry_parity(1'b0, r_mem[req_index][req_way].tag);
`endif
         end
         if (w_op == OP_LOOKUP && w_hit) begin
            r_plru[req_index] <= w_plru_next;
            if (req_write) r_mem[req_index][w_hit_way].dirty <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state             <= ST_CLEAR;
         r_clr_idx           <= '0;
         r_resp_valid        <= 1'b0;
         r_resp_hit          <= 1'b0;
         r_resp_way          <= '0;
         r_resp_dirty        <= 1'b0;
         r_resp_victim_tag   <= '0;
         r_resp_victim_valid <= 1'b0;
`ifdef CACHE_TAG_PARITY_EN
         r_parity_err        <= 1'b0;
`endif
      end else begin
         r_resp_valid <= w_accept && (w_op == OP_LOOKUP);
`ifdef CACHE_TAG_PARITY_EN
         r_parity_err <= w_accept && (w_op == OP_LOOKUP) && (|w_perr);
`endif
         if (w_accept && w_op == OP_LOOKUP) begin
            r_resp_hit          <= w_hit;
            r_resp_way          <= w_resp_way;
            r_resp_dirty        <= r_mem[req_index][w_resp_way].dirty;
            r_resp_victim_tag   <= TAG_W'(r_mem[req_index][w_resp_way].tag);
            r_resp_victim_valid <= r_mem[req_index][w_resp_way].valid;
         end
         if (r_state == ST_CLEAR) begin
            r_clr_idx <= r_clr_idx + 1'b1;
            if (&r_clr_idx) r_state <= ST_IDLE;
         end else if (flush_start) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
         end
      end
   end

   assign resp_valid        = r_resp_valid;
   assign resp_hit          = r_resp_hit;
   assign resp_way          = r_resp_way;
   assign resp_dirty        = r_resp_dirty;
   assign resp_victim_tag   = r_resp_victim_tag;
   assign resp_victim_valid = r_resp_victim_valid;

endmodule

// File: tb/tb_sa_cache_tag_array.sv
// tb_sa_cache_tag_array: directed + random checks of sa_cache_tag_array against a behavioural model.
module tb_sa_cache_tag_array;

   localparam int WAYS = 4, SETS = 1024, TAG_W = 18, IDX_W = 10, WAY_W = 2;

   logic             clk = 1'b0, rst_n = 1'b0;
   logic             req_valid = 1'b0, req_write = 1'b0, flush_start = 1'b0;
   logic [1:0]       req_op = 2'd3;
   logic [IDX_W-1:0] req_index = '0;
   logic [TAG_W-1:0] req_tag = '0;
   logic [WAY_W-1:0] req_way = '0;
   logic             req_ready, flush_busy, resp_valid, resp_hit, resp_dirty, resp_victim_valid, parity_err;
   logic [WAY_W-1:0] resp_way;
   logic [TAG_W-1:0] resp_victim_tag;

   int checks = 0, errors = 0;

   bit m_v [SETS][WAYS];
   bit m_d [SETS][WAYS];
   int m_t [SETS][WAYS];
   bit m_p [SETS][WAYS-1];

   always #5 clk = ~clk;

   sa_cache_tag_array dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_index(req_index), .req_tag(req_tag), .req_way(req_way), .req_write(req_write),
      .flush_start(flush_start), .flush_busy(flush_busy), .resp_valid(resp_valid), .resp_hit(resp_hit),
      .resp_way(resp_way), .resp_dirty(resp_dirty), .resp_victim_tag(resp_victim_tag),
      .resp_victim_valid(resp_victim_valid), .parity_err(parity_err)
   );

   task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
      end
   endtask

   task automatic m_clear();
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            m_v[s][w] = 1'b0; m_d[s][w] = 1'b0; m_t[s][w] = 0;
         end
         for (int n = 0; n < WAYS - 1; n++) m_p[s][n] = 1'b0;
      end
   endtask

   // Walk the way range by halves; each node bit says which half holds the victim.
   function automatic int m_victim(input int s);
      int lo = 0, hi = WAYS, node = 0, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (m_p[s][node]) begin lo = mid; node = 2 * node + 2; end
         else begin hi = mid; node = 2 * node + 1; end
      end
      return lo;
   endfunction

   task automatic m_touch(input int s, input int way);
      int lo = 0, hi = WAYS, node = 0, mid;
      while (hi - lo > 1) begin
         mid = (lo + hi) / 2;
         if (way >= mid) begin m_p[s][node] = 1'b0; lo = mid; node = 2 * node + 2; end
         else begin m_p[s][node] = 1'b1; hi = mid; node = 2 * node + 1; end
      end
   endtask

   task automatic step(input int op, input int idx, input int tag, input int way, input bit wr,
                       input bit vld, input bit fl);
      bit e_hit, e_dirty, e_vv;
      int e_way, e_vt;
      @(negedge clk);
      req_valid = vld; req_op = op[1:0]; req_index = idx[IDX_W-1:0];
      req_tag = tag[TAG_W-1:0]; req_way = way[WAY_W-1:0]; req_write = wr; flush_start = fl;
      e_hit = 1'b0; e_way = 0;
      for (int w = WAYS - 1; w >= 0; w--)
         if (m_v[idx][w] && m_t[idx][w] == tag) begin e_hit = 1'b1; e_way = w; end
      if (!e_hit) begin
         e_way = m_victim(idx);
         for (int w = WAYS - 1; w >= 0; w--) if (!m_v[idx][w]) e_way = w;
      end
      e_dirty = m_d[idx][e_way]; e_vt = m_t[idx][e_way]; e_vv = m_v[idx][e_way];
      @(posedge clk);
      if (vld) begin
         if (op == 0 && e_hit) begin
            m_touch(idx, e_way);
            if (wr) m_d[idx][e_way] = 1'b1;
         end else if (op == 1) begin
            m_v[idx][way] = 1'b1; m_d[idx][way] = wr; m_t[idx][way] = tag;
            m_touch(idx, way);
         end else if (op == 2) begin
            m_v[idx][way] = 1'b0; m_d[idx][way] = 1'b0;
         end
      end
      #1;
      if (vld && op == 0) begin
         chk("resp_valid", 32'(resp_valid), 1);
         chk("resp_hit", 32'(resp_hit), 32'(e_hit));
         chk("resp_way", 32'(resp_way), e_way);
         chk("resp_dirty", 32'(resp_dirty), 32'(e_dirty));
         if (!e_hit) begin
            chk("resp_victim_tag", 32'(resp_victim_tag), e_vt);
            chk("resp_victim_valid", 32'(resp_victim_valid), 32'(e_vv));
         end
         chk("parity_err", 32'(parity_err), 0);
      end else
         chk("resp_idle", 32'(resp_valid), 0);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!req_ready && n < 3000);
   endtask

   initial begin
      int n, r, idx_tab[5];
      idx_tab = '{0, 1, 2, 7, 1023};
      m_clear();
      req_valid = 1'b1; req_op = 2'd3;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_busy", 32'(flush_busy), 1);
      chk("rst_resp_valid", 32'(resp_valid), 0);
      chk("rst_resp_hit", 32'(resp_hit), 0);
      chk("rst_resp_way", 32'(resp_way), 0);
      chk("rst_victim", 32'(resp_victim_tag), 0);
      chk("rst_parity", 32'(parity_err), 0);
      @(negedge clk) rst_n = 1'b1;
      wait_ready(n);
      chk("clear_cycles", n, 1024);
      chk("ready_busy", 32'(flush_busy), 0);

      step(0, 5, 1, 0, 0, 1, 0);
      chk("tp_cold_hit", 32'(resp_hit), 0);
      chk("tp_cold_way", 32'(resp_way), 0);
      chk("tp_cold_vv", 32'(resp_victim_valid), 0);

      for (int w = 0; w < 4; w++) step(1, 7, 'hA + w, w, 0, 1, 0);
      step(0, 7, 'hC, 0, 0, 1, 0);
      chk("tp_hit_c", 32'(resp_hit), 1);
      chk("tp_way_c", 32'(resp_way), 2);

      step(0, 7, 'hA, 0, 1, 1, 0);
      step(0, 7, 'hA, 0, 0, 1, 0);
      chk("tp_dirty_a", 32'(resp_dirty), 1);

      for (int w = 0; w < 4; w++) step(0, 7, 'hA + w, 0, 0, 1, 0);
      step(0, 7, 'hF, 0, 0, 1, 0);
      chk("tp_plru_way", 32'(resp_way), 0);
      chk("tp_plru_tag", 32'(resp_victim_tag), 'hA);

      step(2, 7, 0, 1, 0, 1, 0);
      step(0, 7, 'hF, 0, 0, 1, 0);
      chk("tp_inval_way", 32'(resp_way), 1);
      chk("tp_inval_vv", 32'(resp_victim_valid), 0);

`ifdef CACHE_TAG_PARITY_EN
      @(negedge clk);
      dut.r_mem[7][2].parity = ~dut.r_mem[7][2].parity;
      req_valid = 1'b1; req_op = 2'd0; req_index = 10'd7; req_tag = 18'hC; req_write = 1'b0;
      @(posedge clk); #1;
      chk("par_hit", 32'(resp_hit), 0);
      chk("par_err", 32'(parity_err), 1);
      step(1, 7, 'hC, 2, 0, 1, 0);
`endif

      step(0, 7, 'hB, 0, 0, 1, 0);
      step(0, 7, 'hC, 0, 0, 1, 1);
      chk("fl_hit", 32'(resp_hit), 1);
      chk("fl_busy", 32'(flush_busy), 1);
      chk("fl_ready", 32'(req_ready), 0);
      flush_start = 1'b0;
      wait_ready(n);
      chk("flush_cycles", n, 1024);
      m_clear();
      step(0, 7, 'hA, 0, 0, 1, 0);
      chk("fl_miss_a", 32'(resp_hit), 0);

      for (int i = 0; i < 2000; i++) begin
         r = int'($urandom_range(0, 9));
         step(r < 5 ? 0 : r < 7 ? 1 : r < 8 ? 2 : 3, idx_tab[$urandom_range(0, 4)],
              int'($urandom_range(0, 5)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 9) != 0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sa_cache_tag_array.md
# sa_cache_tag_array

Parametrised set-associative tag array for the L1 data cache, successor to the single-port direct-mapped tag memory. Holds tag, valid and dirty state for every way of every set, performs hit/miss lookup with one-cycle latency, and tracks tree pseudo-LRU replacement state per set. A built-in clear sequencer invalidates the whole array after reset or on request, so no initial-block preload is needed. Sits between the cache controller FSM and the data array; the controller uses `resp_*` to pick the hit way or the victim way.

## Interface
- `WAYS`, 4: associativity; power of two, 2..8.
- `SETS`, 1024: number of sets; power of two.
- `TAG_W`, 18: tag bits stored per way.
- `IDX_W`, `$clog2(SETS)`: derived set index width.
- `WAY_W`, `$clog2(WAYS)`: derived way number width.

- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: array can accept; request accepted when `req_valid && req_ready`.
- `req_op` in 2: 0 LOOKUP, 1 FILL, 2 INVAL, 3 NOP.
- `req_index` in IDX_W: set index.
- `req_tag` in TAG_W: tag to compare (LOOKUP) or write (FILL).
- `req_way` in WAY_W: target way (FILL, INVAL).
- `req_write` in 1: LOOKUP is a store; a hit sets dirty. FILL: initial dirty value.
- `flush_start` in 1: pulse to request a full clear.
- `flush_busy` out 1: clear sequencer active.
- `resp_valid` out 1: LOOKUP result valid (one-cycle pulse).
- `resp_hit` out 1: tag matched a valid way.
- `resp_way` out WAY_W: hit way, or victim way on a miss.
- `resp_dirty` out 1: dirty bit of `resp_way` before this access.
- `resp_victim_tag` out TAG_W: stored tag of the victim way (for writeback address).
- `resp_victim_valid` out 1: the victim way held valid data.
- `parity_err` out 1: only with `CACHE_TAG_PARITY_EN`.

## Operation
- Storage per set: WAYS × {valid, dirty, tag} plus WAYS-1 tree-PLRU bits.
- FSM states: CLEAR, IDLE. Reset state CLEAR with clear index 0. CLEAR writes one set per cycle (valid, dirty and PLRU bits zeroed), index 0..SETS-1. After the final set the FSM moves to IDLE. `flush_start` in IDLE moves the FSM to CLEAR with index 0. `flush_start` in CLEAR is ignored; the sequence does not restart.
- `req_ready` = (state == IDLE). `flush_busy` = (state == CLEAR).
- LOOKUP: compare `req_tag` against all valid ways.
  - Hit: `resp_hit`=1, `resp_way`=matching way, hit way made MRU. If `req_write`, its dirty bit is set.
  - Miss: victim = lowest-numbered invalid way; if all ways are valid, the PLRU way. `resp_victim_*` describe the victim. PLRU and contents are unchanged on a miss.
  - More than one matching way is illegal. If it occurs, the lowest way is reported.
- FILL: writes {valid=1, dirty=`req_write`, tag=`req_tag`} into `req_way` and makes that way MRU. No response.
- INVAL: clears valid and dirty of `req_way`. PLRU is unchanged. No response.
- NOP: accepted with no effect.

## Timing
- Reset values: `req_ready`=0, `flush_busy`=1, `resp_valid`=0, all `resp_*`=0, `parity_err`=0.
- Clear duration: SETS cycles after `rst_n` deasserts or after the cycle `flush_start` is sampled in IDLE.
- If `rst_n` asserts mid-clear or mid-operation, the block returns immediately to CLEAR index 0.
- LOOKUP latency: one cycle. Accepted at edge N; `resp_*` valid in cycle N+1 for one cycle.
- Throughput: one request per cycle.
- Updates are committed at the acceptance edge. A request at edge N+1 to the same set sees the update from edge N: write-before-read, no stale read.
- `flush_start` and an accepted request in the same cycle: the request completes (LOOKUP response still issued), then CLEAR begins on the next cycle.

## Configuration
- `CACHE_TAG_PARITY_EN` defined: each way stores an even-parity bit over {valid, tag}.
  - Parity is checked on every LOOKUP. On a mismatch, that way is treated as invalid for hit detection.
  - `parity_err` pulses with `resp_valid`.
- `CACHE_TAG_PARITY_EN` undefined: no parity storage, and `parity_err` is tied to 0.

## Structure
- `cache_tag_pkg` holds:
  - `tag_op_e` enum (LOOKUP/FILL/INVAL/NOP).
  - parametrised `tag_entry_t` struct {valid, dirty, tag[, parity]}.
  - op encoding constants.
- Sub-module `plru_tree`, combinational:
  - inputs: PLRU bits and the accessed way.
  - outputs: updated bits and the victim way.

## Test plan
- Reset, then hold `req_valid`=1: `req_ready`=0 for exactly 1024 cycles, then 1. LOOKUP tag 0x1 at index 5 misses with victim way 0 and `resp_victim_valid`=0.
- FILL ways 0-3 of index 7 with tags 0xA-0xD, then LOOKUP 0xC: hit, way 2, one cycle later.
- Store-hit dirty: LOOKUP with `req_write`=1 on tag 0xA at index 7, then LOOKUP 0xA: `resp_dirty`=1.
- PLRU: with index 7 full, hit ways 0,1,2,3 in order, then LOOKUP 0xF: miss, victim way 0 with `resp_victim_tag`=0xA.
- INVAL way 1 at index 7, then LOOKUP 0xF: victim way 1. `flush_start` mid-stream: a back-to-back LOOKUP still responds and `flush_busy` rises the next cycle. After clear, LOOKUP 0xA misses.
- With `CACHE_TAG_PARITY_EN`: force a parity bit flip on way 2, then LOOKUP 0xC: `resp_hit`=0 and `parity_err`=1.
